// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the two-digit display decode path.
// Segment order: bit 6 = seg a ... bit 0 = seg g.
//   seg7_t       : one 7-segment code
//   SEG7_LUT     : digit -> code table
//   seg7_encode  : digit -> code (0 for digits above 9)
//   seg7_decode  : code -> {digit, valid}
//   dec_state_e  : delta decoder reference state
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic {EMPTY, TRACK} dec_state_e;

  // Descending range: the leftmost literal lands on index 9.
  localparam seg7_t SEG7_LUT [9:0] = '{
    7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic seg7_t seg7_encode(input logic [3:0] digit);
    seg7_t code;
    code = '0;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) code = SEG7_LUT[i];
    end
    return code;
  endfunction

  function automatic void seg7_decode(input seg7_t code, output logic [3:0] digit,
                                      output logic valid);
    digit = '0;
    valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (code == SEG7_LUT[i]) begin
        digit = 4'(i);
        valid = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one 7-segment code back to a BCD digit.
//   code  : 7-segment code, bit 6 = seg a ... bit 0 = seg g
//   digit : decoded digit 0..9 (0 when invalid)
//   valid : code is one of the ten legal patterns
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  seg7_t      code,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = '0;
    valid = 1'b0;
    seg7_decode(code, digit, valid);
  end

endmodule

// File: rtl/seg7_delta_decoder.sv
// Decodes a stream of two-digit 7-segment beats to a value 0..99 and recovers
// the per-step increment by differencing against the last good value.
//   clk, rst    : clock, synchronous active-high reset
//   s_valid/s_ready/s_data : input beat, s_data[1] tens code, s_data[0] units code
//   m_valid/m_ready        : output handshake (single register stage)
//   m_value     : decoded value (0 on invalid code)
//   m_delta     : recovered increment (0 whenever a flag is set)
//   m_first     : first good beat since reset
//   m_wrap      : value went down, accumulator wrapped
//   m_error     : invalid code or increment above 2^W-1
//   err_count   : saturating count of error beats
module seg7_delta_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [1:0][6:0]    s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [6:0]         m_value,
  output logic [W-1:0]       m_delta,
  output logic               m_first,
  output logic               m_wrap,
  output logic               m_error,
  output logic [CNT_W-1:0]   err_count
);

  // A 7-bit difference can never exceed 127, so wide W simply never errors.
  localparam int unsigned MaxDelta = (W >= 7) ? 127 : ((1 << W) - 1);

  logic [3:0] tens_digit, units_digit;
  logic       tens_ok, units_ok;

  seg7_digit_decode u_tens (
    .code  (s_data[1]),
    .digit (tens_digit),
    .valid (tens_ok)
  );

  seg7_digit_decode u_units (
    .code  (s_data[0]),
    .digit (units_digit),
    .valid (units_ok)
  );

  dec_state_e        state_q, state_d;
  logic [6:0]        prev_q, prev_d;
  logic [CNT_W-1:0]  err_count_q;
  logic              m_valid_q;
  logic [6:0]        m_value_q, value_d;
  logic [W-1:0]      m_delta_q, delta_d;
  logic              m_first_q, first_d;
  logic              m_wrap_q, wrap_d;
  logic              m_error_q, error_d;

  logic [6:0] value;
  logic [6:0] diff;
  logic       accept;

  assign value   = 7'(tens_digit) * 7'd10 + 7'(units_digit);
  assign diff    = value - prev_q;
  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  // Beat classification; checks are ordered so exactly one outcome applies.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    value_d = value;
    delta_d = '0;
    first_d = 1'b0;
    wrap_d  = 1'b0;
    error_d = 1'b0;
    if (!(tens_ok && units_ok)) begin
      // Bad code: reference and state untouched so the next good beat still diffs.
      error_d = 1'b1;
      value_d = '0;
    end else if (state_q == EMPTY) begin
      first_d = 1'b1;
      prev_d  = value;
      state_d = TRACK;
    end else if (value < prev_q) begin
      wrap_d = 1'b1;
      prev_d = value;
    end else if (32'(diff) > MaxDelta) begin
      error_d = 1'b1;
      prev_d  = value;
    end else begin
      delta_d = W'(diff);
      prev_d  = value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      err_count_q <= '0;
      m_valid_q   <= 1'b0;
      m_value_q   <= '0;
      m_delta_q   <= '0;
      m_first_q   <= 1'b0;
      m_wrap_q    <= 1'b0;
      m_error_q   <= 1'b0;
    end else if (accept) begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      m_valid_q <= 1'b1;
      m_value_q <= value_d;
      m_delta_q <= delta_d;
      m_first_q <= first_d;
      m_wrap_q  <= wrap_d;
      m_error_q <= error_d;
      if (error_d && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_value   = m_value_q;
  assign m_delta   = m_delta_q;
  assign m_first   = m_first_q;
  assign m_wrap    = m_wrap_q;
  assign m_error   = m_error_q;
  assign err_count = err_count_q;

endmodule
